actuator_cmd_sequencer: RTL and testbench
=========================================

ACTUATOR_CMD_SEQUENCER -- requirements
Module: actuator_cmd_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per duration tick; legal range is 2 or more; benches use 4.
REQ-002 Parameter DEPTH, default 4, command FIFO entries; power of two.
REQ-003 clk  in  1  single system clock; all state on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_we  in  1  one-cycle write strobe from processor MMIO decode.
REQ-006 cmd_data  in  32  [1:0] requested mode, [17:2] duration in ticks, [31:18] ignored.
REQ-007 abort  in  1  flush queue and force idle.
REQ-008 ovf_clr  in  1  clears the overflow flag.
REQ-009 mode  out  32  registered mode word for the actuator controller: 0 retract, 1 extend, 2 auto-toggle.
REQ-010 busy  out  1  high when the FSM is not IDLE.
REQ-011 fifo_count  out  $clog2(DEPTH)+1  number of queued commands.
REQ-012 fifo_full  out  1  fifo_count equals DEPTH.
REQ-013 overflow  out  1  sticky; a write was dropped.

Function
REQ-014 FIFO: a write is accepted when cmd_we is high and fifo_full is low (as of before the edge); count increments at that edge.
REQ-015 A write while full is dropped, FIFO is unchanged, and overflow is set; a pop in the same cycle does not make room for that write.
REQ-016 Simultaneous accepted write and pop leaves fifo_count unchanged; FIFO order is strictly first-in first-out; pointers wrap modulo DEPTH.
REQ-017 FSM states: IDLE, LOAD, RUN.
REQ-018 IDLE behaviour: mode=0; if fifo_count>0, the FSM goes to LOAD at the next edge.
REQ-019 LOAD behaviour: pop the head entry and latch mode and duration.
REQ-020 Invalid mode 3 is latched as 0.
REQ-021 Duration-0 entry in LOAD: the entry is discarded and mode is unchanged; the FSM goes to LOAD if fifo_count after the pop is >0, otherwise to IDLE.
REQ-022 Nonzero-duration entry in LOAD: the FSM goes to RUN; mode register, tick prescaler (0) and remaining (duration) are loaded at the same edge.
REQ-023 RUN: the prescaler counts 0..TICK_DIV-1; at terminal count it wraps and remaining decrements.
REQ-024 RUN end of command: when remaining==1 at terminal count, the command ends; the FSM goes to LOAD if fifo_count>0, otherwise to IDLE; mode keeps its value through LOAD.
REQ-025 Back-to-back commands: mode is held for exactly duration*TICK_DIV+1 cycles (one LOAD cycle of gap).
REQ-026 Return to idle: at the edge entering IDLE from RUN, mode becomes 0.
REQ-027 Write-to-mode latency from IDLE with an empty FIFO: a write accepted at edge k gives LOAD at k+1 and the new mode at k+2.
REQ-028 Abort takes priority over all other activity: at the edge with abort high, FIFO is emptied, FSM=IDLE, mode=0 and the prescaler clears. A cmd_we in the same cycle is dropped and does not set overflow.
REQ-029 ovf_clr clears overflow at the next edge; if an overflow occurs in the same cycle, overflow remains 1.
REQ-030 busy = (state != IDLE); mode[31:2] is always 0.

Reset
REQ-031 At the edge with reset high: state=IDLE, FIFO empty (count 0, pointers 0), mode=0, busy=0, fifo_full=0, overflow=0, prescaler=0, remaining=0.
REQ-032 Reset mid-RUN discards the current command and all queued commands; no input is acted upon in a cycle where reset is high.

Verification (TICK_DIV=4, DEPTH=4)
REQ-033 Single command: write mode=1, duration=3 -> mode=1 two edges later for 12 cycles, then mode=0 and busy=0.
REQ-034 Chain: write {1,dur 2} then {2,dur 1} -> mode=1 for 8 cycles, then one LOAD cycle with mode still 1, then mode=2 for 4 cycles, then 0.
REQ-035 Overflow: write 6 commands in 6 consecutive cycles while RUN holds a long command -> fifo_full=1, overflow=1, only the first 4 queued commands execute in order; ovf_clr then gives overflow=0.
REQ-036 Zero and invalid: queue {1,dur 0},{3,dur 2} -> the first is skipped with mode never equal to 1; the second drives mode=0 for 8 cycles with busy=1.
REQ-037 Abort mid-RUN with 3 queued and simultaneous cmd_we -> next edge: mode=0, fifo_count=0, busy=0, overflow unchanged.
REQ-038 Reset asserted mid-RUN -> all REQ-031 values are reached at that edge; commands written after reset deasserts behave as in REQ-033.

Source files
------------

// File: rtl/actuator_cmd_sequencer.sv
// actuator_cmd_sequencer
//   Queues actuator commands written by the processor and plays them out one
//   at a time, holding each requested mode for its duration (in ticks of
//   TICK_DIV clock cycles) before moving on to the next queued command.
//
// Ports
//   clk         system clock, all state updates on posedge
//   reset       synchronous, active-high reset
//   cmd_we      one-cycle command write strobe
//   cmd_data    [1:0] mode, [17:2] duration in ticks, [31:18] ignored
//   abort       flush the queue and force the sequencer idle
//   ovf_clr     clear the sticky overflow flag
//   mode        registered mode word (0 retract, 1 extend, 2 auto-toggle)
//   busy        sequencer not idle
//   fifo_count  number of queued commands
//   fifo_full   queue holds DEPTH commands
//   overflow    sticky; a write was dropped because the queue was full
module actuator_cmd_sequencer #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_we,
    input  logic [31:0]               cmd_data,
    input  logic                      abort,
    input  logic                      ovf_clr,
    output logic [31:0]               mode,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      fifo_full,
    output logic                      overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TC       = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    // Queue storage: {duration[15:0], mode[1:0]}
    logic [17:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;

    state_t         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [15:0]    rem_q, rem_d;

    logic           full;
    logic           push;
    logic           pop;
    logic [17:0]    head;
    logic [1:0]     head_mode;
    logic [15:0]    head_dur;
    logic           unused_cmd_bits;

    assign unused_cmd_bits = ^cmd_data[31:18];

    assign full      = (count_q == FULL_CNT);
    // Fullness is judged before the edge, so a same-cycle pop never frees room
    assign push      = cmd_we && !full && !abort;
    assign pop       = (state_q == LOAD) && (count_q != '0) && !abort;

    assign head      = mem_q[rd_ptr_q];
    assign head_mode = (head[1:0] == 2'd3) ? 2'd0 : head[1:0];
    assign head_dur  = head[17:2];

    // Queue pointers, occupancy and sticky overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
        // A dropped write in the same cycle wins over the clear
        if (ovf_clr) ovf_d = 1'b0;
        if (cmd_we && full && !abort) ovf_d = 1'b1;
    end

    // Sequencer next state
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                mode_d = 2'd0;
                if (count_q != '0) state_d = LOAD;
            end
            LOAD: begin
                if (head_dur == 16'd0) begin
                    // Skip the empty command; mode is left untouched
                    state_d = (count_d != '0) ? LOAD : IDLE;
                end else begin
                    state_d = RUN;
                    mode_d  = head_mode;
                    presc_d = '0;
                    rem_d   = head_dur;
                end
            end
            RUN: begin
                if (presc_q == TC) begin
                    presc_d = '0;
                    rem_d   = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        if (count_q != '0) begin
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                            mode_d  = 2'd0;
                        end
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                mode_d  = 2'd0;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
            mode_d  = 2'd0;
            presc_d = '0;
            rem_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            mode_q   <= 2'd0;
            presc_q  <= '0;
            rem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            mode_q   <= mode_d;
            presc_q  <= presc_d;
            rem_q    <= rem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wr_ptr_q] <= cmd_data[17:0];
    end

    assign mode       = {{30{1'b0}}, mode_q};
    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;
    assign fifo_full  = full;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_actuator_cmd_sequencer.sv
module tb_actuator_cmd_sequencer;

    localparam int unsigned TD = 4;
    localparam int unsigned DP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_data = '0;
    logic        abort = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [31:0] mode;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic        overflow;

    always #5 clk = ~clk;

    actuator_cmd_sequencer #(.TICK_DIV(TD), .DEPTH(DP)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_we     (cmd_we),
        .cmd_data   (cmd_data),
        .abort      (abort),
        .ovf_clr    (ovf_clr),
        .mode       (mode),
        .busy       (busy),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    typedef struct {
        logic [31:0] m;
        logic        b;
        logic [2:0]  c;
    } exp_t;

    typedef struct {
        logic [1:0]  m;
        logic [15:0] d;
        logic [31:0] em;
    } vec_t;

    typedef struct {
        logic [31:0] m;
        int          len;
    } run_t;

    exp_t sbq[$];
    run_t rq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Per-cycle scoreboard: one expectation popped at every falling edge
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            n_tests++;
            if (mode !== e.m || busy !== e.b || fifo_count !== e.c ||
                fifo_full !== (e.c == 3'd4)) begin
                n_fail++;
                $display("FAIL sb t=%0t: mode=%0d busy=%0b count=%0d full=%0b, expected mode=%0d busy=%0b count=%0d",
                         $time, mode, busy, fifo_count, fifo_full, e.m, e.b, e.c);
            end
        end
    end

    function automatic logic [31:0] cw(input logic [1:0] m, input logic [15:0] d);
        return {14'd0, d, m};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] m, input logic b, input logic [2:0] c, input int n);
        exp_t e;
        e.m = m; e.b = b; e.c = c;
        repeat (n) sbq.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (sbq.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain timeout: %0d expectations left, required 0", sbq.size());
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Single command from idle with an empty queue
    task automatic run_single(input logic [1:0] m, input logic [15:0] d, input logic [31:0] em);
        cmd_we = 1'b1;
        cmd_data = cw(m, d);
        @(posedge clk); #1;
        cmd_we = 1'b0;
        push_exp(0, 1'b0, 3'd1, 1);
        push_exp(0, 1'b1, 3'd1, 1);
        if (d != 16'd0) push_exp(em, 1'b1, 3'd0, int'(d) * TD);
        push_exp(0, 1'b0, 3'd0, 1);
        wait_drain(400);
    endtask

    vec_t        vecs[6];
    logic [31:0] oc[6];

    initial begin
        vecs[0] = '{m: 2'd1, d: 16'd3, em: 32'd1};
        vecs[1] = '{m: 2'd2, d: 16'd1, em: 32'd2};
        vecs[2] = '{m: 2'd3, d: 16'd2, em: 32'd0};
        vecs[3] = '{m: 2'd0, d: 16'd2, em: 32'd0};
        vecs[4] = '{m: 2'd2, d: 16'd0, em: 32'd0};
        vecs[5] = '{m: 2'd1, d: 16'd1, em: 32'd1};
        oc[0] = cw(2'd2, 16'd1);
        oc[1] = cw(2'd1, 16'd1);
        oc[2] = cw(2'd2, 16'd2);
        oc[3] = cw(2'd1, 16'd2);
        oc[4] = cw(2'd2, 16'd1);
        oc[5] = cw(2'd1, 16'd1);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst mode", mode, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst count", {29'd0, fifo_count}, 32'd0);
        check("rst full", {31'd0, fifo_full}, 32'd0);
        check("rst ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single commands, including invalid mode and zero duration
        for (int i = 0; i < 6; i++) run_single(vecs[i].m, vecs[i].d, vecs[i].em);

        // Chain of two commands with a one-cycle LOAD gap
        cmd_we = 1'b1;
        cmd_data = cw(2'd1, 16'd2);
        @(posedge clk); #1;
        cmd_data = cw(2'd2, 16'd1);
        push_exp(0, 1'b0, 3'd1, 1);
        push_exp(0, 1'b1, 3'd2, 1);
        push_exp(1, 1'b1, 3'd1, 8);
        push_exp(1, 1'b1, 3'd1, 1);
        push_exp(2, 1'b1, 3'd0, 4);
        push_exp(0, 1'b0, 3'd0, 1);
        @(posedge clk); #1;
        cmd_we = 1'b0;
        wait_drain(200);

        // Zero-duration entry skipped, invalid mode runs as 0
        cmd_we = 1'b1;
        cmd_data = cw(2'd1, 16'd0);
        @(posedge clk); #1;
        cmd_data = cw(2'd3, 16'd2);
        push_exp(0, 1'b0, 3'd1, 1);
        push_exp(0, 1'b1, 3'd2, 1);
        push_exp(0, 1'b1, 3'd1, 1);
        push_exp(0, 1'b1, 3'd0, 8);
        push_exp(0, 1'b0, 3'd0, 1);
        @(posedge clk); #1;
        cmd_we = 1'b0;
        wait_drain(200);

        // Overflow: six writes behind a long command
        cmd_we = 1'b1;
        cmd_data = cw(2'd1, 16'd5);
        @(posedge clk); #1;
        cmd_we = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rq.push_back('{m: 32'd2, len: 5});
        rq.push_back('{m: 32'd1, len: 5});
        rq.push_back('{m: 32'd2, len: 9});
        rq.push_back('{m: 32'd1, len: 8});
        for (int i = 0; i < 6; i++) begin
            cmd_we = 1'b1;
            cmd_data = oc[i];
            @(posedge clk); #1;
        end
        cmd_we = 1'b0;
        @(negedge clk);
        check("ovf count", {29'd0, fifo_count}, 32'd4);
        check("ovf full", {31'd0, fifo_full}, 32'd1);
        check("ovf flag", {31'd0, overflow}, 32'd1);
        check("ovf long mode", mode, 32'd1);
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf cleared", {31'd0, overflow}, 32'd0);
        check("ovf count kept", {29'd0, fifo_count}, 32'd4);
        begin
            logic [31:0] prev;
            int len;
            int k;
            bit first;
            @(negedge clk);
            prev = mode; len = 1; first = 1'b1; k = 0;
            while (!(mode == 32'd0 && busy == 1'b0) && k < 300) begin
                @(negedge clk);
                k++;
                if (mode == prev) begin
                    len++;
                end else begin
                    if (!first) begin
                        n_tests++;
                        if (rq.size() == 0) begin
                            n_fail++;
                            $display("FAIL ovf run: extra run mode=%0d len=%0d, required none", prev, len);
                        end else begin
                            run_t r;
                            r = rq.pop_front();
                            if (prev !== r.m || len != r.len) begin
                                n_fail++;
                                $display("FAIL ovf run: mode=%0d len=%0d, required mode=%0d len=%0d",
                                         prev, len, r.m, r.len);
                            end
                        end
                    end
                    first = 1'b0;
                    prev = mode;
                    len = 1;
                end
            end
            if (k >= 300) begin
                n_tests++;
                n_fail++;
                $display("FAIL ovf timeout: busy=%0b mode=%0d, required idle", busy, mode);
            end
        end
        check("ovf runs left", rq.size(), 32'd0);
        repeat (3) @(negedge clk);
        check("ovf stays idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Abort mid-RUN with three queued and a simultaneous write
        cmd_we = 1'b1;
        cmd_data = cw(2'd2, 16'd5);
        @(posedge clk); #1;
        cmd_data = cw(2'd1, 16'd1);
        repeat (3) begin @(posedge clk); #1; end
        cmd_we = 1'b0;
        @(negedge clk);
        check("abt pre count", {29'd0, fifo_count}, 32'd3);
        check("abt pre mode", mode, 32'd2);
        cmd_we = 1'b1;
        abort = 1'b1;
        cmd_data = cw(2'd1, 16'd1);
        @(posedge clk); #1;
        cmd_we = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("abt mode", mode, 32'd0);
        check("abt count", {29'd0, fifo_count}, 32'd0);
        check("abt busy", {31'd0, busy}, 32'd0);
        check("abt ovf", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        check("abt write dropped", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Reset mid-RUN with a full queue and overflow set
        cmd_we = 1'b1;
        cmd_data = cw(2'd2, 16'd5);
        @(posedge clk); #1;
        cmd_data = cw(2'd1, 16'd1);
        repeat (5) begin @(posedge clk); #1; end
        cmd_we = 1'b0;
        @(negedge clk);
        check("rmr pre ovf", {31'd0, overflow}, 32'd1);
        check("rmr pre busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        cmd_we = 1'b1;
        cmd_data = cw(2'd1, 16'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        cmd_we = 1'b0;
        @(negedge clk);
        check("rmr mode", mode, 32'd0);
        check("rmr busy", {31'd0, busy}, 32'd0);
        check("rmr count", {29'd0, fifo_count}, 32'd0);
        check("rmr full", {31'd0, fifo_full}, 32'd0);
        check("rmr ovf", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        check("rmr input ignored", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        run_single(2'd1, 16'd3, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
